// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte-addressed load/store initiator with RMW sub-word stores
module load_store_unit #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              reqWrite,
    input  logic [1:0]        reqSize,
    input  logic              reqUnsigned,
    input  logic [ADDR_W-1:0] reqAddr,
    input  logic [DATA_W-1:0] reqWriteData,
    output logic              busy,
    output logic              done,
    output logic              fault,
    output logic [DATA_W-1:0] loadData,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] writeData,
    output logic              memRead,
    output logic              memWrite,
    input  logic [DATA_W-1:0] readData
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_t            state_q;
    logic              busy_q;
    logic              done_q;
    logic              fault_q;
    logic              mem_read_q;
    logic              mem_write_q;
    logic [ADDR_W-1:0] address_q;
    logic [DATA_W-1:0] write_data_q;
    logic [DATA_W-1:0] load_data_q;
    logic              is_write_q;
    logic [1:0]        size_q;
    logic              unsigned_q;
    logic [1:0]        lane_q;
    logic [15:0]       sub_wdata_q;

    logic              req_fault;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;
    logic [DATA_W-1:0] load_data_d;
    logic [DATA_W-1:0] merged_d;

    always_comb begin
        req_fault = 1'b0;
        case (reqSize)
            SZ_HALF: req_fault = reqAddr[0];
            SZ_WORD: req_fault = (reqAddr[1:0] != 2'b00);
            SZ_BYTE: req_fault = 1'b0;
            default: req_fault = 1'b1;
        endcase
    end

    // Lane extraction and insertion both key off the latched byte offset.
    always_comb begin
        rd_byte = readData[7:0];
        case (lane_q)
            2'd0: rd_byte = readData[7:0];
            2'd1: rd_byte = readData[15:8];
            2'd2: rd_byte = readData[23:16];
            default: rd_byte = readData[31:24];
        endcase
        rd_half = lane_q[1] ? readData[31:16] : readData[15:0];

        load_data_d = readData;
        if (size_q == SZ_BYTE) begin
            load_data_d = unsigned_q ? {{(DATA_W-8){1'b0}}, rd_byte}
                                     : {{(DATA_W-8){rd_byte[7]}}, rd_byte};
        end else if (size_q == SZ_HALF) begin
            load_data_d = unsigned_q ? {{(DATA_W-16){1'b0}}, rd_half}
                                     : {{(DATA_W-16){rd_half[15]}}, rd_half};
        end

        merged_d = readData;
        if (size_q == SZ_BYTE) begin
            case (lane_q)
                2'd0: merged_d[7:0]   = sub_wdata_q[7:0];
                2'd1: merged_d[15:8]  = sub_wdata_q[7:0];
                2'd2: merged_d[23:16] = sub_wdata_q[7:0];
                default: merged_d[31:24] = sub_wdata_q[7:0];
            endcase
        end else if (size_q == SZ_HALF) begin
            if (lane_q[1]) merged_d[31:16] = sub_wdata_q;
            else           merged_d[15:0]  = sub_wdata_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            fault_q      <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            address_q    <= '0;
            write_data_q <= '0;
            load_data_q  <= '0;
            is_write_q   <= 1'b0;
            size_q       <= 2'b00;
            unsigned_q   <= 1'b0;
            lane_q       <= 2'b00;
            sub_wdata_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        is_write_q  <= reqWrite;
                        size_q      <= reqSize;
                        unsigned_q  <= reqUnsigned;
                        lane_q      <= reqAddr[1:0];
                        sub_wdata_q <= reqWriteData[15:0];
                        address_q   <= {2'b00, reqAddr[ADDR_W-1:2]};
                        busy_q      <= 1'b1;
                        if (req_fault) begin
                            fault_q <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else if (reqWrite && reqSize == SZ_WORD) begin
                            write_data_q <= reqWriteData;
                            mem_write_q  <= 1'b1;
                            state_q      <= S_WR;
                        end else begin
                            mem_read_q <= 1'b1;
                            state_q    <= S_RD;
                        end
                    end
                end
                S_RD: begin
                    mem_read_q <= 1'b0;
                    if (is_write_q) begin
                        write_data_q <= merged_d;
                        mem_write_q  <= 1'b1;
                        state_q      <= S_WR;
                    end else begin
                        load_data_q <= load_data_d;
                        done_q      <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_WR: begin
                    mem_write_q <= 1'b0;
                    done_q      <= 1'b1;
                    state_q     <= S_DONE;
                end
                default: begin
                    done_q  <= 1'b0;
                    fault_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign fault     = fault_q;
    assign memRead   = mem_read_q;
    assign memWrite  = mem_write_q;
    assign address   = address_q;
    assign writeData = write_data_q;
    assign loadData  = load_data_q;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store initiator between the datapath core and the word-organised data memory. It accepts one byte-addressed load or store per request and drives the memory's `address`/`writeData`/`memRead`/`memWrite` interface. Byte and halfword stores are performed as read-modify-write sequences, and loads are returned sign- or zero-extended. Misaligned and illegal accesses are rejected without touching memory.

## Interface
- `DATA_W`, default 32: data word width (fixed at 32; byte-lane logic assumes 4 lanes).
- `ADDR_W`, default 32: byte-address width on the core side and word-index width on the memory side.

- `clk`  in  1: the single clock; everything samples on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req`  in  1: request strobe; sampled only in IDLE.
- `reqWrite`  in  1: 1 = store, 0 = load.
- `reqSize`  in  2: 00 byte, 01 halfword, 10 word, 11 illegal.
- `reqUnsigned`  in  1: load zero-extends when 1, sign-extends when 0.
- `reqAddr`  in  ADDR_W: byte address.
- `reqWriteData`  in  DATA_W: store data, right-aligned (bits [7:0] for byte, [15:0] for half).
- `busy`  out  1: high whenever the state is not IDLE.
- `done`  out  1: one-cycle pulse marking completion.
- `fault`  out  1: high only together with `done`, for a rejected request.
- `loadData`  out  DATA_W: extended load result; holds until the next successful load.
- `address`  out  ADDR_W: memory word index, `reqAddr >> 2`.
- `writeData`  out  DATA_W: memory write word.
- `memRead`  out  1: memory read enable.
- `memWrite`  out  1: memory write enable.
- `readData`  in  DATA_W: memory read word. It is combinational from `address` while `memRead`=1.

## Operation
- Little-endian lanes.
  - Byte k = `reqAddr[1:0]` occupies bits [8k+7:8k].
  - Half h = `reqAddr[1]` occupies bits [16h+15:16h].
- Fault conditions:
  - `reqSize`=11.
  - Half with `reqAddr[0]`=1.
  - Word with `reqAddr[1:0]`≠0.
- On acceptance in IDLE (`req`=1), latch all request fields and set `address`.
- State machine: IDLE, RD, WR, DONE.
  - IDLE → DONE with fault=1, and no memory strobe, if the request faults.
  - IDLE → RD for a load or a sub-word store.
  - IDLE → WR for a word store.
  - RD: `memRead`=1. At the edge that ends RD, capture `readData`.
    - Load: the extended lane goes to `loadData`, then go to DONE.
    - Sub-word store: merge the new lane into the captured word, then go to WR.
  - WR: `memWrite`=1 and `writeData` is valid, either the full `reqWriteData` or the merged word. Then go to DONE.
  - DONE: `done`=1, and `fault` as latched. Always go to IDLE next.
- `memRead` and `memWrite` are never high together. Each is high for exactly one cycle per access.
- `req` outside IDLE is ignored. It is neither queued nor acknowledged.
- Stores and faults leave `loadData` unchanged.

## Timing
- Reset values: state IDLE, and `busy`, `done`, `fault`, `memRead`, `memWrite` all 0. `address`, `writeData` and `loadData` are 0.
- Latency is counted from the edge that accepts `req` (cycle 0) to the cycle in which `done`=1:
  - fault: cycle 1.
  - load: cycle 2, with RD in cycle 1.
  - word store: cycle 2, with WR in cycle 1.
  - sub-word store: cycle 3, with RD in cycle 1 and WR in cycle 2.
- `loadData` is valid in the DONE cycle and is stable afterwards.
- The earliest next acceptance is the cycle after DONE, i.e. IDLE. Peak throughput is one access per 3 cycles (4 for RMW).
- Reset mid-operation:
  - `rst` sampled high returns to IDLE at that edge and drops all strobes. No `done` is issued for the aborted request.
  - A write whose WR cycle coincides with the reset edge is committed by memory. Memory is not reset.
  - An aborted RD does not update `loadData`.
- `rst` and `req` high in the same cycle: reset wins and the request is dropped.

## Test plan
- Preload word0=0x8899AABB and word1=0x11223344.
- Word load, reqAddr=0x4: `memRead`=1 for exactly one cycle with `address`=1; `done` in cycle 2; `loadData`=0x11223344.
- Sub-word loads:
  - Signed byte, 0x1: `loadData`=0xFFFFFFAA.
  - Unsigned byte, 0x1: 0x000000AA.
  - Signed half, 0x2: 0xFFFF8899.
  - Unsigned half, 0x6: 0x00001122.
- Byte store of 0x5A to 0x6:
  - RD in cycle 1 with `address`=1.
  - WR in cycle 2 with `writeData`=0x115A3344.
  - `done` in cycle 3; memory word1=0x115A3344.
  - Word store 0xDEADBEEF to 0x0: `done` in cycle 2, with no `memRead` cycle.
- Faults:
  - Word load at 0x2: `done`=`fault`=1 in cycle 1, with no `memRead`/`memWrite` ever; `loadData` is unchanged.
  - Repeat for half at 0x3 and for `reqSize`=11.
- Requests while busy:
  - `req` pulses during RD/WR/DONE are ignored: exactly one `done` per accepted request.
  - A new `req` in the IDLE cycle after DONE is accepted.
- Reset during an RMW byte store:
  - `rst` during RD: no `done`, no write, and memory is unchanged.
  - `rst` during WR: the merged word is written and there is no `done`.
  - After either, all outputs equal their reset values.
